// File: rtl/parallel_byte_receiver.sv
// Receive side of the parallel byte link: synchronises data/strobe, qualifies
// each strobe high period into a single byte push, and buffers bytes in a FIFO.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | strobe low, waiting for a synchronised rising level
// ST_QUALIFY  | strobe high, counting cycles until MIN_HIGH is reached
// ST_WAIT_LOW | byte taken (or just out of reset); wait for strobe to drop
module parallel_byte_receiver #(
  parameter int          DEPTH    = 16,
  parameter int          MIN_HIGH = 4,
  parameter logic [7:0]  NEWLINE  = 8'h0A
) (
  input  logic                     iCLK,
  input  logic                     reset,
  input  logic [7:0]               iData,
  input  logic                     iStrobe,
  output logic [7:0]               oData,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic [15:0]              oLineCount,
  output logic                     oOverflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (MIN_HIGH > 1) ? $clog2(MIN_HIGH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MIN_HIGH - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_QUALIFY  = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;

  logic          r_s1, r_s2;
  logic [7:0]    r_d1, r_d2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_line_count;
  logic          r_overflow;

  logic w_push, w_pop, w_full, w_wr;

  // Strobe flops reset high so a strobe held high through reset looks "already seen".
  always_ff @(posedge iCLK) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_d1 <= 8'h00;
      r_d2 <= 8'h00;
    end else begin
      r_s1 <= iStrobe;
      r_s2 <= r_s1;
      r_d1 <= iData;
      r_d2 <= r_d1;
    end
  end

  always_comb begin
    w_push = 1'b0;
    if (r_s2) begin
      if (r_state == ST_IDLE && MIN_HIGH == 1)
        w_push = 1'b1;
      else if (r_state == ST_QUALIFY && r_cnt == CNT_LAST)
        w_push = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (reset) begin
      r_state <= ST_WAIT_LOW;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_WAIT_LOW: begin
          if (!r_s2) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (r_s2) begin
            if (MIN_HIGH == 1) begin
              r_state <= ST_WAIT_LOW;
            end else begin
              r_cnt   <= CW'(1);
              r_state <= ST_QUALIFY;
            end
          end
        end
        ST_QUALIFY: begin
          if (!r_s2) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_LOW;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT_LOW;
        end
      endcase
    end
  end

  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = oValid && iReady;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge iCLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_d2;
  end

  always_ff @(posedge iCLK) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_line_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_push && !w_wr) r_overflow <= 1'b1;
      if (w_wr && r_d2 == NEWLINE) r_line_count <= r_line_count + 16'd1;
    end
  end

  assign oData      = r_mem[r_rd_ptr];
  assign oValid     = (r_level != '0);
  assign oLevel     = r_level;
  assign oLineCount = r_line_count;
  assign oOverflow  = r_overflow;

endmodule

// File: tb/tb_parallel_byte_receiver.sv
// Self-checking bench for parallel_byte_receiver: byte-level queue model,
// table of strobe lengths, directed corner sequences and a random stream.
module tb_parallel_byte_receiver;

  localparam int         DEPTH    = 16;
  localparam int         MIN_HIGH = 4;
  localparam logic [7:0] NEWLINE  = 8'h0A;

  logic        iCLK = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  iData = 8'h00;
  logic        iStrobe = 1'b0;
  logic [7:0]  oData;
  logic        oValid;
  logic        iReady = 1'b0;
  logic [4:0]  oLevel;
  logic [15:0] oLineCount;
  logic        oOverflow;

  parallel_byte_receiver #(.DEPTH(DEPTH), .MIN_HIGH(MIN_HIGH), .NEWLINE(NEWLINE)) dut (
    .iCLK(iCLK), .reset(reset), .iData(iData), .iStrobe(iStrobe),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oLevel(oLevel),
    .oLineCount(oLineCount), .oOverflow(oOverflow)
  );

  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad = 0;

  // Model: bytes expected in order at the consumer, plus line/overflow state.
  logic [7:0] q[$];
  logic [15:0] exp_lines = 16'd0;
  logic        exp_ovf = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         hi;
    bit         exp_push;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Consumer side: every handshake must deliver the model's next byte.
  always @(negedge iCLK) begin
    if (!reset && oValid && iReady) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_order: got %0h expected no byte (model empty)", oData);
      end else begin
        chk("pop_order", {24'h0, oData}, {24'h0, q.pop_front()});
      end
    end
  end

  task automatic model_push(input logic [7:0] d);
    if (q.size() < DEPTH) begin
      q.push_back(d);
      if (d == NEWLINE) exp_lines = exp_lines + 16'd1;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int hi, input int lo);
    if (hi >= MIN_HIGH) model_push(d);
    iData = d;
    repeat (2) tick();
    iStrobe = 1'b1;
    repeat (hi) tick();
    iStrobe = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    iReady = 1'b1;
    while (oValid && n < 200) begin
      tick();
      n++;
    end
    if (oValid) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got oValid=1 expected 0 within 200 cycles");
    end
    iReady = 1'b0;
    tick();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    exp_lines = 16'd0;
    exp_ovf = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    bit done;

    vecs[0] = '{8'h11, 1,  1'b0};
    vecs[1] = '{8'h22, 3,  1'b0};
    vecs[2] = '{8'h33, 4,  1'b1};
    vecs[3] = '{8'h44, 5,  1'b1};
    vecs[4] = '{8'h0A, 20, 1'b1};
    vecs[5] = '{8'h55, 2,  1'b0};
    vecs[6] = '{8'h66, 4,  1'b1};

    repeat (2) tick();
    reset = 1'b0;
    chk("rst_valid", oValid, 0);
    chk("rst_level", oLevel, 0);
    chk("rst_lines", oLineCount, 0);
    chk("rst_ovf", oOverflow, 0);
    repeat (3) tick();

    // Single byte: exact latency of MIN_HIGH+1 edges after strobe is first sampled.
    iData = 8'h61;
    repeat (2) tick();
    iStrobe = 1'b1;
    repeat (5) tick();
    chk("lat_not_yet", oValid, 0);
    tick();
    chk("lat_valid", oValid, 1);
    chk("lat_data", oData, 8'h61);
    chk("lat_level", oLevel, 1);
    q.push_back(8'h61);
    repeat (4) tick();
    iStrobe = 1'b0;
    repeat (8) tick();
    chk("one_push", oLevel, 1);
    drain();

    // Strobe lengths around the qualification threshold.
    exp_cnt = 0;
    foreach (vecs[i]) begin
      send_byte(vecs[i].data, vecs[i].hi, 8);
      if (vecs[i].exp_push) exp_cnt++;
      chk($sformatf("vec%0d_level", i), oLevel, exp_cnt);
    end
    chk("vec_lines", oLineCount, exp_lines);
    drain();

    // Stream with a live consumer.
    do_reset();
    iReady = 1'b1;
    send_byte(8'h61, 8, 8);
    send_byte(8'h62, 8, 8);
    send_byte(8'h63, 8, 8);
    send_byte(8'h64, 8, 8);
    send_byte(8'h65, 8, 8);
    send_byte(8'h0A, 8, 8);
    chk("stream_empty", q.size(), 0);
    chk("stream_lines", oLineCount, 1);
    chk("stream_ovf", oOverflow, 0);
    iReady = 1'b0;

    // Overflow: 17 bytes into 16 slots, last one dropped.
    do_reset();
    for (int i = 0; i < 17; i++) send_byte(8'(i), 8, 8);
    chk("ovf_level", oLevel, DEPTH);
    chk("ovf_flag", oOverflow, exp_ovf);
    chk("ovf_lines", oLineCount, exp_lines);
    drain();
    chk("ovf_sticky", oOverflow, 1);

    // Full FIFO with a pop on the push edge.
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_byte(8'h20 + 8'(i), 6, 6);
    chk("full_level", oLevel, DEPTH);
    iData = 8'hA5;
    repeat (2) tick();
    iStrobe = 1'b1;
    repeat (5) tick();
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    q.push_back(8'hA5);
    chk("fullpop_level", oLevel, DEPTH);
    chk("fullpop_ovf", oOverflow, 0);
    repeat (3) tick();
    iStrobe = 1'b0;
    repeat (8) tick();
    chk("fullpop_level2", oLevel, DEPTH);
    drain();

    // Reset while a strobe is being qualified, held high through release.
    send_byte(8'h0A, 6, 8);
    send_byte(8'h42, 6, 8);
    iData = 8'h99;
    repeat (2) tick();
    iStrobe = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    q.delete();
    exp_lines = 16'd0;
    exp_ovf = 1'b0;
    chk("midrst_valid", oValid, 0);
    chk("midrst_level", oLevel, 0);
    chk("midrst_lines", oLineCount, 0);
    chk("midrst_ovf", oOverflow, 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("midrst_nocap", oLevel, 0);
    iStrobe = 1'b0;
    repeat (6) tick();
    send_byte(8'h77, 5, 8);
    chk("midrst_next_level", oLevel, 1);
    chk("midrst_next_data", oData, 8'h77);
    drain();

    // Random stream against the model, consumer ready ~75% of cycles.
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [7:0] d;
          d = ($urandom_range(0, 3) == 0) ? NEWLINE : 8'($urandom);
          send_byte(d, $urandom_range(1, 10), $urandom_range(6, 10));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          iReady = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    iReady = 1'b0;
    repeat (20) tick();
    drain();
    chk("rand_lines", oLineCount, exp_lines);
    chk("rand_ovf", oOverflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
